fec23_block_encoder_ble: RTL and testbench

- Serial (15,10) shortened-Hamming FEC 2/3 encoder. Sits directly downstream of Block_Segmentation_ble and consumes its 10-bit serial blocks (`data_out`/`valid_out`).
- Appends 5 parity bits from g(x)=x^5+x^4+x^2+1 to each block.
- Buffers up to two 15-bit codewords and serializes them under valid/ready toward the whitening/modulator path.
- Drives a hold signal. Integration uses it to gate the segmentation `enable` at block boundaries.

---
 rtl/fec23_ble_pkg.sv | 34 +++
 rtl/fec23_codeword_fifo_ble.sv | 62 ++++++
 rtl/fec23_block_encoder_ble.sv | 153 +++++++++++++++
 tb/tb_fec23_block_encoder_ble.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fec23_ble_pkg.sv
// Shared definitions for the (15,10) shortened-Hamming FEC 2/3 encoder.
// Holds block geometry, the generator polynomial, collector state
// encodings and the codeword bit-order helpers used by the encoder.
package fec23_ble_pkg;

    // Block geometry: K data bits plus R parity bits per codeword
    localparam int K = 10;
    localparam int R = 5;
    localparam int N = K + R;

    // Generator g(x) = x^5 + x^4 + x^2 + 1, coefficients x^4..x^0 (x^5 implicit)
    localparam logic [R-1:0] GEN_POLY = 5'b10101;

    // Collector state encodings
    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] PAD     = 1'b1;

    // A stored codeword is {data bits in arrival order, p[4]..p[0]}, so the
    // first data bit received lives in bit N-1 and is transmitted first.
    typedef logic [N-1:0] codeword_t;

    // Maps a serializer index (0 = first bit on the wire) to a word bit position
    function automatic logic [3:0] cw_bit_pos(input logic [3:0] idx);
        return 4'(N - 1) - idx;
    endfunction

    // One step of the systematic division LFSR for a single message bit
    function automatic logic [R-1:0] lfsr_step(input logic [R-1:0] p, input logic b);
        logic fb;
        fb = b ^ p[R-1];
        return {p[R-2:0], 1'b0} ^ (fb ? GEN_POLY : '0);
    endfunction

endpackage

// File: rtl/fec23_codeword_fifo_ble.sv
// Two-entry codeword FIFO between the collector and the serializer.
// A push while full is accepted only if a pop happens at the same edge;
// otherwise the word is ignored here and the caller flags the drop.
module fec23_codeword_fifo_ble
    import fec23_ble_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  codeword_t   push_data,
    input  logic        pop,
    output codeword_t   head_data,
    output logic [1:0]  count,
    output logic        full,
    output logic        empty
);

    codeword_t  mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    // Qualify push/pop against occupancy; a full FIFO still accepts a push
    // when the head is leaving at the same edge
    always_comb begin
        do_pop  = pop && (count != 2'd0);
        do_push = push && ((count != 2'd2) || do_pop);
    end

    // Storage, pointers and occupancy count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head word and status flags derived from registered state
    always_comb begin
        head_data = mem[rd_ptr];
        full      = (count == 2'd2);
        empty     = (count == 2'd0);
    end

endmodule

// File: rtl/fec23_block_encoder_ble.sv
// Serial (15,10) shortened-Hamming FEC 2/3 block encoder.
// Collects 10-bit serial blocks, appends 5 parity bits from
// g(x) = x^5 + x^4 + x^2 + 1, buffers up to two codewords and
// serializes them under valid/ready. in_hold tells the upstream
// segmentation not to start a new block while both slots are full.
// Optional macro FEC23_BLOCK_COUNT_EN adds a popped-codeword counter
// (blocks_encoded) with a synchronous clear (count_clr).
module fec23_block_encoder_ble
    import fec23_ble_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_data,
    input  logic       in_valid,
    input  logic       flush,
    output logic       out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       in_hold,
    output logic       overflow,
    output logic       busy
`ifdef FEC23_BLOCK_COUNT_EN
    ,
    input  logic       count_clr,
    output logic [9:0] blocks_encoded
`endif
);

    logic [0:0]    state;
    logic [3:0]    bit_cnt;
    logic [K-1:0]  data_sr;
    logic [R-1:0]  lfsr;
    logic [3:0]    ser_idx;

    logic          take_bit;
    logic          bit_val;
    logic [R-1:0]  lfsr_next;
    logic [K-1:0]  sr_next;
    logic          last_bit;
    logic          start_pad;

    logic          fifo_push;
    codeword_t     push_word;
    logic          fifo_pop;
    codeword_t     head_word;
    logic [1:0]    fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          drop;

    // Collector datapath: in PAD a zero is injected every cycle, in COLLECT
    // only qualified input bits advance the data shifter and the LFSR
    always_comb begin
        take_bit  = (state == PAD) || in_valid;
        bit_val   = (state == COLLECT) && in_data;
        lfsr_next = lfsr_step(lfsr, bit_val);
        sr_next   = {data_sr[K-2:0], bit_val};
        last_bit  = take_bit && (bit_cnt == 4'(K - 1));
        fifo_push = last_bit;
        push_word = {sr_next, lfsr_next};
        // A flush that lands on the K-th bit is absorbed by the normal push;
        // a flush with nothing collected (and nothing arriving) does nothing
        start_pad = (state == COLLECT) && flush && !last_bit
                    && ((bit_cnt != 4'd0) || in_valid);
    end

    // Collector state, bit counter, data shifter and parity LFSR
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= COLLECT;
            bit_cnt <= 4'd0;
            data_sr <= '0;
            lfsr    <= '0;
        end else begin
            if (take_bit) begin
                if (last_bit) begin
                    bit_cnt <= 4'd0;
                    data_sr <= '0;
                    lfsr    <= '0;
                    state   <= COLLECT;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    data_sr <= sr_next;
                    lfsr    <= lfsr_next;
                end
            end
            if (start_pad) begin
                state <= PAD;
            end
        end
    end

    fec23_codeword_fifo_ble u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .head_data (head_word),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Serializer outputs and handshake decode; out_data is forced low when
    // nothing is valid so the line idles at zero
    always_comb begin
        out_valid = (fifo_count != 2'd0);
        out_data  = out_valid && head_word[cw_bit_pos(ser_idx)];
        fifo_pop  = out_valid && out_ready && (ser_idx == 4'(N - 1));
        drop      = fifo_push && fifo_full && !fifo_pop;
        in_hold   = fifo_full;
        busy      = (bit_cnt != 4'd0) || (state == PAD) || !fifo_empty;
    end

    // Serializer bit index; wraps with the pop of the head word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ser_idx <= 4'd0;
        end else if (out_valid && out_ready) begin
            if (ser_idx == 4'(N - 1)) begin
                ser_idx <= 4'd0;
            end else begin
                ser_idx <= ser_idx + 4'd1;
            end
        end
    end

    // Sticky overflow: a completed word lost to a full FIFO, or input that
    // arrived while the collector was padding a partial block
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (drop || ((state == PAD) && in_valid)) begin
            overflow <= 1'b1;
        end
    end

`ifdef FEC23_BLOCK_COUNT_EN
    // Count of codewords fully serialized; wraps naturally at 10 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blocks_encoded <= 10'd0;
        end else if (count_clr) begin
            blocks_encoded <= 10'd0;
        end else if (fifo_pop) begin
            blocks_encoded <= blocks_encoded + 10'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_fec23_block_encoder_ble.sv
// Self-checking bench for fec23_block_encoder_ble.
// Expected codeword bits are queued when a block is driven and popped by a
// monitor on every output handshake.
module tb_fec23_block_encoder_ble;

    logic clk;
    logic reset;
    logic in_data;
    logic in_valid;
    logic flush;
    logic out_data;
    logic out_valid;
    logic out_ready;
    logic in_hold;
    logic overflow;
    logic busy;
`ifdef FEC23_BLOCK_COUNT_EN
    logic       count_clr;
    logic [9:0] blocks_encoded;
`endif

    int   checks = 0;
    int   failures = 0;
    int   hs_cnt = 0;
    logic exp_q[$];
    logic rand_ready = 1'b0;
    logic stall_prev = 1'b0;
    logic prev_bit = 1'b0;

    fec23_block_encoder_ble dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .in_hold   (in_hold),
        .overflow  (overflow),
        .busy      (busy)
`ifdef FEC23_BLOCK_COUNT_EN
        ,
        .count_clr      (count_clr),
        .blocks_encoded (blocks_encoded)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference encoder: remainder of m(x)*x^5 by polynomial long division
    function automatic logic [14:0] refEncode(input logic [9:0] d);
        logic [14:0] r;
        logic [14:0] g;
        g = 15'b000000000110101;
        r = {d, 5'b00000};
        for (int i = 14; i >= 5; i--) begin
            if (r[i]) r = r ^ (g << (i - 5));
        end
        return {d, r[4:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic pushCodeword(input logic [14:0] cw);
        for (int i = 14; i >= 0; i--) exp_q.push_back(cw[i]);
    endtask

    // Drive the first n bits of d (MSB first), optionally with random idle gaps
    task automatic applyStimulus(input logic [9:0] d, input int n, input int max_gap);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = d[9-i];
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = 1'b0;
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic drainAll(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(tag, 32'(n < 2000), 32'd1);
    endtask

    // Scoreboard monitor: compares each accepted bit and checks stall stability
    initial begin
        logic e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    checkOutput("stall_valid", 32'(out_valid), 32'd1);
                    checkOutput("stall_data", 32'(out_data), 32'(prev_bit));
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_bit_qdepth", 32'(exp_q.size()), 32'd1);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("cw_bit", 32'(out_data), 32'(e));
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_bit   = out_data;
            end
        end
    end

    // Random backpressure driver
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int base;
        int n;
        int vcnt;
        logic [9:0] d;

        reset = 1'b0; in_data = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
`ifdef FEC23_BLOCK_COUNT_EN
        count_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_in_hold", 32'(in_hold), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] all-zero block");
        pushCodeword(15'b000000000000000);
        applyStimulus(10'b0000000000, 10, 0);
        checkOutput("latency_valid", 32'(out_valid), 32'd1);
        vcnt = 1;
        n = 0;
        while (n < 40) begin
            @(posedge clk); #1;
            n++;
            if (!out_valid) break;
            vcnt++;
        end
        checkOutput("zero_valid_cycles", 32'(vcnt), 32'd15);
        drainAll("zero_drain");

        $display("[TB] first-bit and last-bit blocks");
        pushCodeword(15'b100000000011010);
        applyStimulus(10'b1000000000, 10, 0);
        drainAll("first_drain");
        pushCodeword(15'b000000000110101);
        applyStimulus(10'b0000000001, 10, 0);
        drainAll("last_drain");

        $display("[TB] partial frame with flush");
        pushCodeword(15'b100000000011010);
        applyStimulus(10'b1000000000, 3, 0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("pad_busy", 32'(busy), 32'd1);
        repeat (6) begin @(posedge clk); #1; end
        checkOutput("pad_not_done", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("pad_done", 32'(out_valid), 32'd1);
        drainAll("partial_drain");
        checkOutput("partial_busy_low", 32'(busy), 32'd0);

        $display("[TB] backpressure and overflow");
        out_ready = 1'b0;
        pushCodeword(refEncode(10'b1011001110));
        applyStimulus(10'b1011001110, 10, 0);
        checkOutput("bp_hold_one", 32'(in_hold), 32'd0);
        pushCodeword(refEncode(10'b0110111001));
        applyStimulus(10'b0110111001, 10, 0);
        checkOutput("bp_hold_two", 32'(in_hold), 32'd1);
        checkOutput("bp_no_ovf", 32'(overflow), 32'd0);
        applyStimulus(10'b1111100000, 10, 0);
        checkOutput("bp_overflow", 32'(overflow), 32'd1);
        checkOutput("bp_hold_kept", 32'(in_hold), 32'd1);
        base = hs_cnt;
        out_ready = 1'b1;
        drainAll("bp_drain");
        checkOutput("bp_bit_count", 32'(hs_cnt - base), 32'd30);
        checkOutput("bp_hold_clear", 32'(in_hold), 32'd0);
        checkOutput("bp_ovf_sticky", 32'(overflow), 32'd1);

        $display("[TB] reset mid-codeword");
        base = hs_cnt;
        pushCodeword(refEncode(10'b1100101011));
        applyStimulus(10'b1100101011, 10, 0);
        n = 0;
        while ((hs_cnt - base) < 7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("mid_seven_bits", 32'(hs_cnt - base), 32'd7);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(posedge clk); #1;
        checkOutput("mid_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid_out_data", 32'(out_data), 32'd0);
        checkOutput("mid_in_hold", 32'(in_hold), 32'd0);
        checkOutput("mid_overflow", 32'(overflow), 32'd0);
        checkOutput("mid_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        pushCodeword(refEncode(10'b0101110011));
        applyStimulus(10'b0101110011, 10, 0);
        drainAll("mid_after_drain");

        $display("[TB] random payload with random stalls");
        base = hs_cnt;
        rand_ready = 1'b1;
        for (int b = 0; b < 100; b++) begin
            n = 0;
            while (in_hold && n < 1000) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("rand_hold_release", 32'(in_hold), 32'd0);
            d = 10'($urandom);
            pushCodeword(refEncode(d));
            applyStimulus(d, 10, 2);
        end
        rand_ready = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        drainAll("rand_drain");
        checkOutput("rand_bit_count", 32'(hs_cnt - base), 32'd1500);
        checkOutput("rand_no_overflow", 32'(overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
